adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 add request, level, held until ack0.
REQ-005 a0, b0  input  W each  requester 0 operands.
REQ-006 cin0  input  1  requester 0 carry-in.
REQ-007 req1, a1, b1, cin1  input  1/W/W/1  requester 1 request, operands and carry-in; same meanings as requester 0.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-009 sum  output  W  result of the most recent completed add.
REQ-010 cout  output  1  carry out of the top nibble of the most recent completed add.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 owner  output  1  index of the requester granted the current or most recent transaction.

Function
REQ-013 The block SHALL contain exactly one 4-bit ripple adder built from four full_adder cells, time-shared across nibbles and requesters.
REQ-014 FSM states SHALL be IDLE, ADD and DONE.
REQ-015 IDLE with no request: stay in IDLE.
REQ-016 IDLE with any request:
- latch the granted requester's a, b and cin into internal registers
- set owner
- clear nibble index to 0
- go to ADD.
REQ-017 Arbitration SHALL be round-robin:
- single request: that requester wins
- both requesting: the requester not served last wins
- the last-served register resets to 1, so req0 wins the first tie.
REQ-018 ADD, each cycle:
- add latched nibble[idx] of a and b plus the carry register
- write the 4-bit result into sum-register nibble[idx]
- store the slice carry-out in the carry register
- increment idx.
REQ-019 The carry register SHALL be loaded with the latched cin on grant.
REQ-020 After nibble NIBBLES-1 is processed, the FSM SHALL go to DONE, and cout SHALL equal that nibble's carry-out.
REQ-021 DONE SHALL:
- last exactly one cycle
- assert ack of owner only
- update the last-served register
- return to IDLE.
REQ-022 Latency: with accept edge E0, ack is high from edge E0+NIBBLES to edge E0+NIBBLES+1 (4 cycles for NIBBLES=4); throughput is one add per NIBBLES+2 cycles.
REQ-023 sum and cout SHALL change only during ADD, and SHALL be stable and valid while ack is high and until the next grant.
REQ-024 Arithmetic SHALL be modulo 2^W: overflow appears only on cout, and sum wraps.
REQ-025 Operand or cin changes after the accept edge SHALL NOT affect the result.
REQ-026 Request deassertion during ADD or DONE SHALL NOT abort the transaction; the ack pulse still occurs.
REQ-027 Requests SHALL be sampled only in IDLE.
- A requester holding req through its ack cycle issues a new request, arbitrated in the following IDLE cycle.
REQ-028 ack0 and ack1 SHALL never be high in the same cycle, and at most one ack SHALL occur per grant.

Reset
REQ-029 Asserting reset SHALL immediately force all of the following, regardless of clock:
- state IDLE, idx 0, carry 0
- sum 0, cout 0
- ack0 0, ack1 0, busy 0
- owner 0, last-served 1.
REQ-030 Reset during ADD or DONE SHALL abort the transaction with no ack pulse.
REQ-031 After reset deasserts, the first rising edge SHALL evaluate IDLE arbitration normally.

Verification
REQ-032 Reset, then req0 with a0=0x1234, b0=0x0FFF, cin0=0 -> ack0 pulses 4 cycles after accept; sum=0x2233, cout=0, owner=0, ack1 stays 0.
REQ-033 req1 with a1=0xFFFF, b1=0x0001, cin1=0 -> sum=0x0000, cout=1, owner=1, ack1 pulses once.
REQ-034 req1 with a1=0x000F, b1=0x0000, cin1=1 -> sum=0x0010, cout=0.
REQ-035 req0 and req1 both asserted immediately after reset and held -> grants alternate 0,1,0,1; each ack is separated by NIBBLES+2 cycles; acks never overlap.
REQ-036 Mid-transaction stimulus:
- change a0/b0 and drop req0 during ADD -> result equals the latched operands and ack0 still pulses
- assert reset during ADD -> busy, sum, cout, owner and both acks read 0 immediately, and no ack follows.

Source files
------------

// File: rtl/adder_arbiter.sv
// Two-requester, nibble-serial adder with round-robin arbitration.
// One 4-bit ripple adder, built from four full_adder cells, is shared by
// both requesters and by every nibble of the operand.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module adder_arbiter #(
  parameter int NIBBLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req0,
  input  logic [4*NIBBLES-1:0]   a0,
  input  logic [4*NIBBLES-1:0]   b0,
  input  logic                   cin0,
  input  logic                   req1,
  input  logic [4*NIBBLES-1:0]   a1,
  input  logic [4*NIBBLES-1:0]   b1,
  input  logic                   cin1,
  output logic                   ack0,
  output logic                   ack1,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   busy,
  output logic                   owner
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_lat;
  logic [W-1:0]     b_lat;
  logic             carry;
  logic [W-1:0]     sum_q;
  logic             cout_q;
  logic             owner_q;
  logic             last_q;

  logic [IDX_W+1:0] base;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic [4:0]       c;

  logic             any_req;
  logic             gnt;

  // Select the nibble currently being worked on.
  assign base  = {idx, 2'b00};
  assign a_nib = a_lat[base +: 4];
  assign b_nib = b_lat[base +: 4];
  assign c[0]  = carry;

  // The single shared 4-bit ripple adder.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder u_fa (
      .a  (a_nib[i]),
      .b  (b_nib[i]),
      .ci (c[i]),
      .s  (s_nib[i]),
      .co (c[i+1])
    );
  end

  // Round-robin: on a tie the requester not served last wins.
  assign any_req = req0 | req1;
  assign gnt     = (req0 & req1) ? ~last_q : req1;

  // Sequencer: grant in IDLE, one nibble per cycle in ADD, one-cycle DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      a_lat   <= '0;
      b_lat   <= '0;
      carry   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            a_lat   <= gnt ? a1 : a0;
            b_lat   <= gnt ? b1 : b0;
            carry   <= gnt ? cin1 : cin0;
            owner_q <= gnt;
            idx     <= '0;
            state   <= ADD;
          end
        end
        ADD: begin
          sum_q[base +: 4] <= s_nib;
          carry            <= c[4];
          if (idx == IDX_LAST) begin
            cout_q <= c[4];
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx <= idx + IDX_ONE;
          end
        end
        DONE: begin
          last_q <= owner_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Acks are decoded from DONE so reset clears them immediately.
  assign ack0  = (state == DONE) && !owner_q;
  assign ack1  = (state == DONE) &&  owner_q;
  assign busy  = (state != IDLE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (NIBBLES = 4, 16-bit operands).

module tb_adder_arbiter;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic          clock;
  logic          reset;
  logic          req0;
  logic [W-1:0]  a0;
  logic [W-1:0]  b0;
  logic          cin0;
  logic          req1;
  logic [W-1:0]  a1;
  logic [W-1:0]  b1;
  logic          cin1;
  logic          ack0;
  logic          ack1;
  logic [W-1:0]  sum;
  logic          cout;
  logic          busy;
  logic          owner;

  int n_checks = 0;
  int n_fail   = 0;

  adder_arbiter #(.NIBBLES(NIBBLES)) dut (
    .clock (clock),
    .reset (reset),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .cin0  (cin0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .cin1  (cin1),
    .ack0  (ack0),
    .ack1  (ack1),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .owner (owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Single-requester transaction: latency, result, owner and ack exclusivity.
  task automatic run_txn(input string tag, input logic who, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] es, input logic ec);
    int  cnt;
    logic got;
    @(negedge clock);
    if (who) begin
      req1 = 1'b1; a1 = a; b1 = b; cin1 = ci;
    end else begin
      req0 = 1'b1; a0 = a; b0 = b; cin0 = ci;
    end
    cnt = 0;
    got = 1'b0;
    while (cnt < 20 && !got) begin
      step();
      cnt++;
      if (cnt == 2) check({tag, "_busy"}, busy, 1);
      if (ack0 | ack1) got = 1'b1;
    end
    check({tag, "_latency"}, cnt - 1, NIBBLES);
    check({tag, "_ack_own"}, who ? ack1 : ack0, 1);
    check({tag, "_ack_oth"}, who ? ack0 : ack1, 0);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_owner"}, owner, who);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check({tag, "_ack_gone"}, {ack0, ack1}, 0);
    check({tag, "_sum_hold"}, sum, es);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin : main
    int   n_acks;
    logic overlap;
    int   at_cyc [4];
    logic who_q  [4];
    logic [W-1:0] sum_q [4];
    logic cout_q [4];
    int   cnt;
    logic got;

    reset = 1'b1;
    req0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
    req1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #1;
    check("rst_busy",  busy, 0);
    check("rst_sum",   sum, 0);
    check("rst_cout",  cout, 0);
    check("rst_owner", owner, 0);
    check("rst_acks",  {ack0, ack1}, 0);
    step();
    step();
    reset = 1'b0;

    run_txn("t1", 1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0);
    run_txn("t2", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_txn("t3", 1'b1, 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0);

    // Both requesting right after reset and held: 0,1,0,1 with spacing NIBBLES+2.
    @(negedge clock);
    reset = 1'b1;
    req0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b0;
    req1 = 1'b1; a1 = 16'h8000; b1 = 16'h8000; cin1 = 1'b1;
    step();
    reset = 1'b0;
    n_acks  = 0;
    overlap = 1'b0;
    for (int cyc = 1; cyc <= 26; cyc++) begin
      step();
      if (ack0 && ack1) overlap = 1'b1;
      if (ack0 || ack1) begin
        if (n_acks < 4) begin
          at_cyc[n_acks] = cyc;
          who_q[n_acks]  = ack1;
          sum_q[n_acks]  = sum;
          cout_q[n_acks] = cout;
        end
        n_acks++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("rr_count",   n_acks, 4);
    check("rr_overlap", overlap, 0);
    if (n_acks >= 4) begin
      check("rr_first_at", at_cyc[0], NIBBLES + 1);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr_who%0d", k), who_q[k], k % 2);
        check($sformatf("rr_sum%0d", k), sum_q[k], (k % 2) ? 16'h0001 : 16'h3333);
        check($sformatf("rr_cout%0d", k), cout_q[k], (k % 2) ? 1 : 0);
        if (k > 0) check($sformatf("rr_gap%0d", k), at_cyc[k] - at_cyc[k-1], NIBBLES + 2);
      end
    end

    // Operand changes and request drop after accept do not disturb the add.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001; cin0 = 1'b0;
    step();
    check("mid_busy", busy, 1);
    req0 = 1'b0; a0 = 16'hFFFF; b0 = 16'hFFFF; cin0 = 1'b1;
    cnt = 0;
    got = 1'b0;
    while (cnt < 10 && !got) begin
      step();
      cnt++;
      if (ack0 | ack1) got = 1'b1;
    end
    check("mid_ack0",  ack0, 1);
    check("mid_ack1",  ack1, 0);
    check("mid_sum",   sum, 16'h0100);
    check("mid_cout",  cout, 0);
    step();
    check("mid_single", {ack0, ack1}, 0);
    step();
    check("mid_no_regrant", busy, 0);

    // Reset in the middle of ADD: immediate clear, no ack afterwards.
    req1 = 1'b1; a1 = 16'h1234; b1 = 16'h0001; cin1 = 1'b0;
    step();
    step();
    check("ra_busy_pre",  busy, 1);
    check("ra_owner_pre", owner, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ra_busy",  busy, 0);
    check("ra_sum",   sum, 0);
    check("ra_cout",  cout, 0);
    check("ra_owner", owner, 0);
    check("ra_acks",  {ack0, ack1}, 0);
    req1 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    got = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      if (ack0 | ack1 | busy) got = 1'b1;
    end
    check("ra_no_ack", got, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
